// File: rtl/dec_scan_ctrl.sv
// -----------------------------------------------------------------------------
// dec_scan_ctrl
//
// Purpose:
//   Sequencer that drives the select and enable inputs of a 2-to-4 decoder.
//   The select walks 0,1,2,3,0,... at one position every DIV clocks while
//   scanning. It can also be held and single-stepped, blanked, or stopped.
//   All outputs are registered so they can feed the decoder directly.
//
// Optional feature (macro DEC_SCAN_GAP_EN):
//   When defined, enable drops for the single cycle in which sel shows a new
//   value, so the decoder never glitches between two outputs. When undefined,
//   enable is governed only by state and blank.
//
// Parameters:
//   DIV    clock cycles per select position while scanning (2 .. 2**CNT_W)
//   CNT_W  width of the divider counter
//
// Ports:
//   clk     in   system clock, rising edge
//   reset   in   synchronous active-high reset
//   run     in   level: 1 = scan continuously, 0 = hold the current position
//   step    in   pulse: advance sel by one while holding
//   stop    in   pulse: return to idle (sel back to 0)
//   blank   in   level: forces enable low, sequencing continues
//   sel     out  decoder select
//   enable  out  decoder enable
//   tick    out  one-cycle pulse in the cycle sel shows a new value
//   wrap    out  one-cycle pulse when that change was 3 -> 0
// -----------------------------------------------------------------------------
module dec_scan_ctrl #(
    parameter int DIV   = 4,
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       step,
    input  logic       stop,
    input  logic       blank,
    output logic [1:0] sel,
    output logic       enable,
    output logic       tick,
    output logic       wrap
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Terminal count of the divider; DIV-1 always fits in CNT_W bits for a
    // legal DIV.
    localparam logic [CNT_W-1:0] TC_VAL  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [1:0]       sel_q,   sel_d;
    logic             en_q,    en_d;
    logic             tick_q,  tick_d;
    logic             wrap_q,  wrap_d;

    // Set when sel moves to its next position on the coming edge.
    logic             adv;

    // -------------------------------------------------------------------------
    // Next-state / next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        adv     = 1'b0;

        if (stop) begin
            state_d = IDLE;
            cnt_d   = '0;
            sel_d   = 2'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (run) begin
                        state_d = SCAN;
                        cnt_d   = '0;
                    end else if (step) begin
                        // Entering HOLD from IDLE does not move sel.
                        state_d = HOLD;
                    end
                end

                SCAN: begin
                    if (cnt_q == TC_VAL) begin
                        cnt_d = '0;
                        adv   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                    // Dropping run on the terminal-count cycle still lets the
                    // advance above happen; only the state changes here.
                    if (!run) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                    end
                end

                HOLD: begin
                    if (run) begin
                        // run wins over a simultaneous step.
                        state_d = SCAN;
                        cnt_d   = '0;
                    end else if (step) begin
                        adv = 1'b1;
                    end
                end

                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    sel_d   = 2'd0;
                end
            endcase

            if (adv) begin
                sel_d = sel_q + 2'd1;
            end
        end

        tick_d = adv;
        wrap_d = adv && (sel_q == 2'd3);

`ifdef DEC_SCAN_GAP_EN
        // Blank the decoder for the one cycle sel settles on its new value.
        en_d = (state_d != IDLE) && !blank && !adv;
`else
        en_d = (state_d != IDLE) && !blank;
`endif
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= 2'd0;
            en_q    <= 1'b0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

    assign sel    = sel_q;
    assign enable = en_q;
    assign tick   = tick_q;
    assign wrap   = wrap_q;

endmodule

// File: tb/tb_dec_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dec_scan_ctrl
//
// Self-checking bench for dec_scan_ctrl (DIV=4). A behavioural model tracks
// the mode, the current position and the edge at which the current position
// began; the DUT outputs are compared against it on every falling edge.
// Directed sequences with literal expectations come first, then a long
// randomized run.
// -----------------------------------------------------------------------------
module tb_dec_scan_ctrl;

    localparam int DIV   = 4;
    localparam int CNT_W = 16;

`ifdef DEC_SCAN_GAP_EN
    localparam bit GAP = 1'b1;
`else
    localparam bit GAP = 1'b0;
`endif

    localparam int M_IDLE = 0;
    localparam int M_SCAN = 1;
    localparam int M_HOLD = 2;

    logic       clk = 1'b0;
    logic       reset, run, step, stop, blank;
    logic [1:0] sel;
    logic       enable, tick, wrap;

    int n_checks = 0;
    int n_errors = 0;

    dec_scan_ctrl #(.DIV(DIV), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .reset  (reset),
        .run    (run),
        .step   (step),
        .stop   (stop),
        .blank  (blank),
        .sel    (sel),
        .enable (enable),
        .tick   (tick),
        .wrap   (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int edges  = 0;   // number of rising edges seen so far
    int m_mode = M_IDLE;
    int m_sel  = 0;
    int m_seg  = 0;   // edge index at which the current SCAN position began
    int m_en   = 0;
    int m_tick = 0;
    int m_wrap = 0;

    always @(posedge clk) begin : model
        int  nmode;
        int  nsel;
        int  nseg;
        bit  adv;
        nmode = m_mode;
        nsel  = m_sel;
        nseg  = m_seg;
        adv   = 1'b0;
        if (reset || stop) begin
            nmode = M_IDLE;
            nsel  = 0;
        end else if (m_mode == M_IDLE) begin
            if (run) begin
                nmode = M_SCAN;
                nseg  = edges;
            end else if (step) begin
                nmode = M_HOLD;
            end
        end else if (m_mode == M_SCAN) begin
            // Each position lasts exactly DIV edges after it began.
            if (edges - m_seg == DIV) adv = 1'b1;
            if (!run) nmode = M_HOLD;
        end else begin
            if (run) begin
                nmode = M_SCAN;
                nseg  = edges;
            end else if (step) begin
                adv = 1'b1;
            end
        end
        if (adv) begin
            nsel = (m_sel + 1) % 4;
            nseg = edges;
        end
        m_mode <= nmode;
        m_sel  <= nsel;
        m_seg  <= nseg;
        m_tick <= (adv && !reset) ? 1 : 0;
        m_wrap <= (adv && !reset && m_sel == 3) ? 1 : 0;
        m_en   <= (nmode != M_IDLE && !blank && !(GAP && adv)) ? 1 : 0;
        edges  <= edges + 1;
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (edges > 0) begin
            check("cmp_sel",    int'(sel),    m_sel);
            check("cmp_enable", int'(enable), m_en);
            check("cmp_tick",   int'(tick),   m_tick);
            check("cmp_wrap",   int'(wrap),   m_wrap);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- stimulus and literal checks ----------------
    initial begin
        int  exp_en;
        bit  found;
        reset = 1'b1; run = 1'b1; step = 1'b0; stop = 1'b0; blank = 1'b0;

        // Reset held two cycles with run high.
        cyc(2);
        check("rst_sel",    int'(sel),    0);
        check("rst_enable", int'(enable), 0);
        check("rst_tick",   int'(tick),   0);
        check("rst_wrap",   int'(wrap),   0);
        reset = 1'b0;

        // Free-run: SCAN entered on the first edge after release.
        cyc(1);
        check("run_en_first",  int'(enable), 1);
        check("run_sel_first", int'(sel),    0);
        cyc(4);
        check("adv1_sel",  int'(sel),  1);
        check("adv1_tick", int'(tick), 1);
        check("adv1_wrap", int'(wrap), 0);
        cyc(1);
        check("adv1_tick_off", int'(tick), 0);
        cyc(3);
        check("adv2_sel", int'(sel), 2);
        cyc(8);
        check("wrap_sel",  int'(sel),  0);
        check("wrap_wrap", int'(wrap), 1);
        cyc(4);
        check("adv5_sel", int'(sel), 1);

        // Hold at sel=1 for 20 cycles.
        run = 1'b0;
        cyc(20);
        check("hold_sel",  int'(sel),  1);
        check("hold_tick", int'(tick), 0);

        // Four steps spaced three cycles apart: 2,3,0,1.
        for (int i = 0; i < 4; i++) begin
            step = 1'b1;
            cyc(1);
            step = 1'b0;
            check("step_sel",  int'(sel),  (i + 2) % 4);
            check("step_tick", int'(tick), 1);
            check("step_wrap", int'(wrap), (i == 2) ? 1 : 0);
            cyc(2);
        end

        // run together with step: back to SCAN, no step.
        run = 1'b1; step = 1'b1;
        cyc(1);
        step = 1'b0;
        check("runstep_sel",  int'(sel),  1);
        check("runstep_tick", int'(tick), 0);

        // Blank for 10 cycles.
        blank = 1'b1;
        cyc(1);
        check("blank_en", int'(enable), 0);
        cyc(9);
        blank = 1'b0;
        cyc(1);
        exp_en = 1;
        if (GAP && tick) exp_en = 0;
        check("unblank_en", int'(enable), exp_en);

        // Stop at sel=2 (run still high: stop must win).
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (sel == 2'd2) found = 1'b1;
            else cyc(1);
        end
        check("wait_sel2_found", int'(found), 1);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        check("stop_sel",    int'(sel),    0);
        check("stop_enable", int'(enable), 0);
        check("stop_tick",   int'(tick),   0);

        // Restart, then drop run exactly on the terminal-count cycle.
        cyc(1);
        check("restart_en", int'(enable), 1);
        cyc(3);
        run = 1'b0;
        cyc(1);
        check("tcdrop_sel",  int'(sel),  1);
        check("tcdrop_tick", int'(tick), 1);
        cyc(5);
        check("tcdrop_hold_sel",  int'(sel),  1);
        check("tcdrop_hold_tick", int'(tick), 0);

        // Reset in the middle of a scan.
        run = 1'b1;
        cyc(6);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        check("midrst_sel",    int'(sel),    0);
        check("midrst_enable", int'(enable), 0);
        check("midrst_tick",   int'(tick),   0);

        // Randomized run.
        for (int k = 0; k < 3000; k++) begin
            reset = ($urandom_range(0, 299) == 0);
            stop  = ($urandom_range(0, 99) == 0);
            step  = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 39) == 0) run   = ~run;
            if ($urandom_range(0, 19) == 0) blank = ~blank;
            cyc(1);
        end
        reset = 1'b0; stop = 1'b0; step = 1'b0;
        cyc(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dec_scan_ctrl.md
Name: dec_scan_ctrl

Overview:
Sequencer that sits directly upstream of the 2-to-4 decoder and drives its select and enable inputs. It cycles the select through 0..3 at a programmable rate, for example to multiplex four display digits or strobe four banks. Supports free-running scan, hold with single-step, blanking and stop. All outputs are registered and connect straight to the decoder's I and enable.

Parameters:
- DIV, 4, clock cycles per select position in SCAN; legal range 2..2^CNT_W.
- CNT_W, 16, width of the internal divider counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- run  input  1  level; 1 = scan continuously, 0 = hold current position.
- step  input  1  one-cycle pulse; advance select by one while in HOLD.
- stop  input  1  one-cycle pulse; return to IDLE.
- blank  input  1  level; forces enable low without affecting sequencing.
- sel  output  2  select to decoder I.
- enable  output  1  enable to decoder.
- tick  output  1  one-cycle pulse coincident with every sel change.
- wrap  output  1  one-cycle pulse coincident with a sel change from 3 to 0.

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset values: state=IDLE, sel=0, enable=0, tick=0, wrap=0, divider cnt=0.
- States: IDLE, SCAN, HOLD.
- Input priority each cycle: reset > stop > run > step.
- Any state, stop=1:
  - next cycle: IDLE, sel=0, cnt=0, tick=0, wrap=0.
- IDLE:
  - run=1 -> SCAN; cnt=0.
  - else step=1 -> HOLD; sel unchanged, no tick.
  - else stay in IDLE.
- SCAN:
  - cnt increments every cycle.
  - When cnt==DIV-1: cnt<=0, sel<=sel+1 (mod 4, 3 wraps to 0), tick<=1, wrap<=1 only if the old sel was 3.
  - Position period is therefore exactly DIV cycles.
  - run=0 -> HOLD; cnt<=0. If run falls on the terminal-count cycle, the advance still occurs on that edge, then HOLD.
  - step is ignored in SCAN.
- HOLD:
  - sel frozen.
  - run=1 -> SCAN with cnt=0; a simultaneous step is ignored.
  - else step=1: sel<=sel+1 (mod 4), tick<=1, wrap<=1 if the old sel was 3; stay in HOLD.
- enable:
  - Registered: enable <= (next_state != IDLE) && !blank.
  - Lags blank and state entry by exactly one cycle.
  - blank does not stop cnt, sel, tick or wrap.
- tick/wrap:
  - Asserted for exactly one cycle, in the same cycle sel shows its new value.
  - Never asserted in IDLE.
- First cycle after reset deassertion with run=1: state=SCAN, enable=1, sel=0. The first advance occurs DIV cycles later.
- Reset mid-scan: all outputs take their reset values on the next edge, regardless of other inputs.

Optional Feature:
- Macro: DEC_SCAN_GAP_EN.
- Defined: enable is forced 0 for exactly the one cycle in which sel takes a new value (SCAN advance or HOLD step). This avoids ghosting on the decoder outputs. enable returns to (!blank) the following cycle. tick/wrap timing is unchanged.
- Undefined: enable stays continuously 1 across sel changes, subject only to blank and state.

Test Plan:
- Reset: hold reset=1 for 2 cycles with run=1 -> sel=0, enable=0, tick=0, wrap=0 throughout.
- Free-run, DIV=4: release reset, run=1 -> enable=1 after 1 cycle. sel sequence 0,1,2,3,0 with each value lasting 4 cycles; tick every 4 cycles; wrap only on 3->0; 1-cycle pulses.
- Hold/step: in SCAN at sel=1, drop run and wait 20 cycles -> sel stays 1, no tick. Then 4 step pulses spaced 3 cycles apart -> sel 2,3,0,1; tick on each step, wrap on the 3->0 step only. run=1 together with step -> SCAN, sel unchanged that cycle.
- Blank: in SCAN assert blank for 10 cycles -> enable=0 from the cycle after assertion; sel and tick keep advancing every 4 cycles. Release -> enable=1 one cycle later.
- Stop/priority: stop pulse at sel=2 in SCAN -> next cycle IDLE, sel=0, enable=0. stop and run high on the same cycle -> IDLE. run dropped on the terminal-count cycle -> sel advances once, then HOLD.
- With DEC_SCAN_GAP_EN: free-run, DIV=4 -> enable=0 for exactly 1 cycle at each sel change, 1 for the other 3 cycles. Without the macro, enable stays constantly 1.
